// File: rtl/pc_unit.sv
// Program-counter unit: next-PC select, misaligned-target trap,
// and a circular return-address stack.
module pc_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4,
    parameter bit              ALIGN_C   = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pc_write,
    input  logic                         is_branch,
    input  logic                         branch_taken,
    input  logic                         is_jump,
    input  logic                         is_jalr,
    input  logic                         is_call,
    input  logic                         is_ret,
    input  logic [XLEN-1:0]              immed,
    input  logic [XLEN-1:0]              rs1_data,
    input  logic [XLEN-1:0]              trap_vec,
    input  logic                         trap_ack,
    output logic [XLEN-1:0]              pc,
    output logic [XLEN-1:0]              pc_plus4,
    output logic                         redirect,
    output logic                         misalign,
    output logic [XLEN-1:0]              bad_addr,
    output logic [XLEN-1:0]              ras_top,
    output logic [$clog2(RAS_DEPTH):0]   ras_count
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [XLEN-1:0] target;
    logic            nonseq;
    logic            tgt_bad;
    logic            accept;
    logic            do_call;
    logic            do_ret;
    logic            empty;
    logic [PW-1:0]   ptr;
    logic [XLEN-1:0] ras [RAS_DEPTH];

    assign pc_plus4 = pc + XLEN'(4);
    assign empty    = (ras_count == '0);
    assign ras_top  = empty ? '0 : ras[ptr];

    always_comb begin
        nonseq = is_jalr | is_jump | (is_branch & branch_taken);
        target = pc_plus4;
        if (is_jalr) begin
            target = (rs1_data + immed) & ~XLEN'(1);
        end else if (nonseq) begin
            target = pc + immed;
        end
        tgt_bad = nonseq & (ALIGN_C ? target[0] : |target[1:0]);
    end

    // RAS only moves on an update that actually loads pc
    assign accept  = pc_write & ~misalign & ~tgt_bad;
    assign do_call = accept & is_call & (is_jump | is_jalr);
    assign do_ret  = accept & is_ret & is_jalr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc        <= RESET_VEC;
            redirect  <= 1'b0;
            misalign  <= 1'b0;
            bad_addr  <= '0;
            ras_count <= '0;
            ptr       <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras[i] <= '0;
            end
        end else begin
            redirect <= 1'b0;
            if (misalign) begin
                if (trap_ack) begin
                    pc       <= trap_vec;
                    misalign <= 1'b0;
                    redirect <= 1'b1;
                end
            end else if (pc_write) begin
                if (tgt_bad) begin
                    misalign <= 1'b1;
                    bad_addr <= target;
                end else begin
                    pc       <= target;
                    redirect <= nonseq;
                end
            end

            // call+ret on a non-empty stack just replaces the top
            if (do_call && do_ret && !empty) begin
                ras[ptr] <= pc_plus4;
            end else if (do_call) begin
                ras[ptr + PW'(1)] <= pc_plus4;
                ptr               <= ptr + PW'(1);
                if (ras_count != FULL) begin
                    ras_count <= ras_count + CW'(1);
                end
            end else if (do_ret && !empty) begin
                ptr       <= ptr - PW'(1);
                ras_count <= ras_count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with a queue-based reference model
// checked on every falling edge.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_write, is_branch, branch_taken, is_jump, is_jalr;
    logic        is_call, is_ret, trap_ack;
    logic [31:0] immed, rs1_data, trap_vec;
    logic [31:0] pc, pc_plus4, bad_addr, ras_top;
    logic        redirect, misalign;
    logic [2:0]  ras_count;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_pc;
    logic        m_red, m_mis;
    logic [31:0] m_bad;
    logic [31:0] m_ras[$];

    pc_unit #(
        .XLEN(32), .RESET_VEC(32'h100), .RAS_DEPTH(4), .ALIGN_C(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pc_write(pc_write),
        .is_branch(is_branch), .branch_taken(branch_taken),
        .is_jump(is_jump), .is_jalr(is_jalr), .is_call(is_call),
        .is_ret(is_ret), .immed(immed), .rs1_data(rs1_data),
        .trap_vec(trap_vec), .trap_ack(trap_ack), .pc(pc),
        .pc_plus4(pc_plus4), .redirect(redirect), .misalign(misalign),
        .bad_addr(bad_addr), .ras_top(ras_top), .ras_count(ras_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h want %h", nm, act, exp);
        else
            passed++;
    endfunction

    // Reference model: pc rules evaluated directly, RAS as a bounded queue
    always @(posedge clk) begin
        logic [31:0] tgt;
        logic        ns, r;
        if (!rst_n) begin
            m_pc = 32'h100; m_red = 0; m_mis = 0; m_bad = 0;
            m_ras.delete();
        end else begin
            r = 0;
            if (m_mis) begin
                if (trap_ack) begin
                    m_pc = trap_vec; m_mis = 0; r = 1;
                end
            end else if (pc_write) begin
                ns = is_jalr || is_jump || (is_branch && branch_taken);
                if (is_jalr) tgt = (rs1_data + immed) & 32'hFFFF_FFFE;
                else if (ns) tgt = m_pc + immed;
                else tgt = m_pc + 4;
                if (ns && tgt[1:0] != 2'b00) begin
                    m_mis = 1; m_bad = tgt;
                end else begin
                    if (is_ret && is_jalr && m_ras.size() > 0)
                        void'(m_ras.pop_back());
                    if (is_call && (is_jump || is_jalr)) begin
                        m_ras.push_back(m_pc + 4);
                        if (m_ras.size() > 4) void'(m_ras.pop_front());
                    end
                    m_pc = tgt; r = ns;
                end
            end
            m_red = r;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 4);
            chk("redirect", {31'b0, redirect}, {31'b0, m_red});
            chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
            if (m_mis) chk("bad_addr", bad_addr, m_bad);
            chk("ras_count", {29'b0, ras_count}, m_ras.size());
            chk("ras_top", ras_top,
                (m_ras.size() == 0) ? 32'h0 : m_ras[m_ras.size() - 1]);
        end
    end

    task automatic idle();
        pc_write = 0; is_branch = 0; branch_taken = 0; is_jump = 0;
        is_jalr = 0; is_call = 0; is_ret = 0; immed = 0; rs1_data = 0;
        trap_ack = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic jalr_to(input logic [31:0] a, input logic c, input logic r);
        idle();
        pc_write = 1; is_jalr = 1; rs1_data = a; is_call = c; is_ret = r;
        step();
        idle();
    endtask

    task automatic call_from(input logic [31:0] base);
        jalr_to(base, 0, 0);
        pc_write = 1; is_jump = 1; is_call = 1; immed = 32'h100;
        step();
        idle();
    endtask

    initial begin
        idle();
        trap_vec = 32'h0;
        rst_n = 0;
        step(); step();
        rst_n = 1;
        chk_en = 1;
        chk("t1 reset pc", pc, 32'h100);
        chk("t1 reset cnt", {29'b0, ras_count}, 32'h0);

        pc_write = 1;
        step(); chk("t1 pc1", pc, 32'h104);
        step(); chk("t1 pc2", pc, 32'h108);
        step(); chk("t1 pc3", pc, 32'h10C);
        idle();

        jalr_to(32'h200, 0, 0);
        pc_write = 1; is_branch = 1; branch_taken = 1; immed = 32'hFFFF_FFF8;
        step();
        chk("t2 taken pc", pc, 32'h1F8);
        chk("t2 taken red", {31'b0, redirect}, 32'h1);
        idle(); step();
        chk("t2 red pulse", {31'b0, redirect}, 32'h0);
        jalr_to(32'h200, 0, 0);
        pc_write = 1; is_branch = 1; immed = 32'hFFFF_FFF8;
        step();
        chk("t2 ntaken pc", pc, 32'h204);
        chk("t2 ntaken red", {31'b0, redirect}, 32'h0);
        idle();

        idle(); pc_write = 1; is_jalr = 1; rs1_data = 32'h1003; immed = 2;
        step();
        chk("t3 jalr pc", pc, 32'h1004);
        idle(); pc_write = 1; is_jalr = 1; rs1_data = 32'h1001; immed = 1;
        step();
        chk("t3 mis", {31'b0, misalign}, 32'h1);
        chk("t3 bad", bad_addr, 32'h1002);
        idle(); pc_write = 1; is_jump = 1; immed = 8;
        step(); step(); step();
        chk("t3 held pc", pc, 32'h1004);
        idle(); trap_vec = 32'h80; trap_ack = 1;
        step();
        chk("t3 trap pc", pc, 32'h80);
        chk("t3 trap red", {31'b0, redirect}, 32'h1);
        step();
        chk("t3 stray ack", pc, 32'h80);
        idle();

        call_from(32'h10); call_from(32'h20); call_from(32'h30);
        call_from(32'h40); call_from(32'h50);
        chk("t4 cnt", {29'b0, ras_count}, 32'h4);
        chk("t4 top", ras_top, 32'h54);
        jalr_to(32'h300, 0, 1); chk("t4 pop1", ras_top, 32'h44);
        jalr_to(32'h300, 0, 1); chk("t4 pop2", ras_top, 32'h34);
        jalr_to(32'h300, 0, 1); chk("t4 pop3", ras_top, 32'h24);
        jalr_to(32'h300, 0, 1); chk("t4 pop4", ras_top, 32'h0);
        jalr_to(32'h300, 0, 1);
        chk("t4 extra", {29'b0, ras_count}, 32'h0);

        call_from(32'h10); call_from(32'h20);
        jalr_to(32'h60, 0, 0);
        jalr_to(32'h400, 1, 1);
        chk("t5 cnt2", {29'b0, ras_count}, 32'h2);
        chk("t5 top2", ras_top, 32'h64);
        jalr_to(32'h300, 0, 1); jalr_to(32'h300, 0, 1);
        jalr_to(32'h60, 0, 0);
        jalr_to(32'h400, 1, 1);
        chk("t5 cnt0", {29'b0, ras_count}, 32'h1);
        chk("t5 top0", ras_top, 32'h64);

        jalr_to(32'hFFFF_FFFC, 0, 0);
        pc_write = 1;
        step();
        chk("t6 wrap", pc, 32'h0);
        idle(); pc_write = 1; is_jump = 1; immed = 2;
        step();
        chk("t6 mis", {31'b0, misalign}, 32'h1);
        idle(); rst_n = 0;
        step();
        chk("t6 rst pc", pc, 32'h100);
        chk("t6 rst mis", {31'b0, misalign}, 32'h0);
        chk("t6 rst cnt", {29'b0, ras_count}, 32'h0);
        rst_n = 1;
        step();

        chk_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
